// File: rtl/exe_fwd_pkg.sv
// Shared types for the EXE operand-forwarding controller.
package exe_fwd_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned NUM_SRC = 6;

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

    // Wide select: full forwarding choice for the complex datapath.
    typedef enum logic [2:0] {
        SEL3_STAGE    = 3'b000,
        SEL3_ALU_MEM  = 3'b001,
        SEL3_WB1      = 3'b010,
        SEL3_ALU2_MEM = 3'b011,
        SEL3_WB2      = 3'b100
    } sel3_t;

    // Narrow select: simple datapath; 11 is never driven.
    typedef enum logic [1:0] {
        SEL2_STAGE   = 2'b00,
        SEL2_ALU_MEM = 2'b01,
        SEL2_WB      = 2'b10
    } sel2_t;

    // Destination bookkeeping carried alongside each pipeline stage.
    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] rd;
        logic             wr2_en;
        logic [REG_W-1:0] rd2;
        logic             is_load;
    } stage_tag_t;

    // Second-result sources only exist on the complex datapath.
    function automatic sel2_t to_sel2(input sel3_t s);
        case (s)
            SEL3_ALU_MEM: return SEL2_ALU_MEM;
            SEL3_WB1:     return SEL2_WB;
            default:      return SEL2_STAGE;
        endcase
    endfunction

    function automatic logic is_second_result(input sel3_t s);
        return (s == SEL3_ALU2_MEM) || (s == SEL3_WB2);
    endfunction

endpackage

// File: rtl/exe_fwd_match.sv
// Per-source forwarding select and load-use detection against EX and MEM tags.
module exe_fwd_match
    import exe_fwd_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  stage_tag_t       ex_tag,
    input  stage_tag_t       mem_tag,
    output sel3_t            sel,
    output logic             load_hit
);

    logic ex_rd_hit;
    logic ex_rd2_hit;
    logic mem_rd_hit;
    logic mem_rd2_hit;
    logic unused_mem_is_load;

    // Register 0 is hardwired, so it never forwards.
    assign ex_rd_hit   = (src != REG_ZERO) && ex_tag.valid  && ex_tag.wr_en   && (ex_tag.rd   == src);
    assign ex_rd2_hit  = (src != REG_ZERO) && ex_tag.valid  && ex_tag.wr2_en  && (ex_tag.rd2  == src);
    assign mem_rd_hit  = (src != REG_ZERO) && mem_tag.valid && mem_tag.wr_en  && (mem_tag.rd  == src);
    assign mem_rd2_hit = (src != REG_ZERO) && mem_tag.valid && mem_tag.wr2_en && (mem_tag.rd2 == src);

    // A load's first result is read back through WB result 1 like any other.
    assign unused_mem_is_load = mem_tag.is_load;

    // Loaded data is not ready in MEM, so an EX-stage load match must stall.
    assign load_hit = ex_rd_hit && ex_tag.is_load;

    // Youngest producer wins; within a stage the second result wins.
    always_comb begin
        sel = SEL3_STAGE;
        if (mem_rd_hit)  sel = SEL3_WB1;
        if (mem_rd2_hit) sel = SEL3_WB2;
        if (ex_rd_hit)   sel = SEL3_ALU_MEM;
        if (ex_rd2_hit)  sel = SEL3_ALU2_MEM;
    end

endmodule

// File: rtl/exe_fwd_ctrl.sv
// EXE operand-forwarding controller: tracks in-flight destinations and
// registers the EXE operand selects one cycle after ID.
module exe_fwd_ctrl
    import exe_fwd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_complex,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rs3,
    input  logic [REG_W-1:0] id_rs4,
    input  logic [REG_W-1:0] id_st_rs,
    input  logic [REG_W-1:0] id_st2_rs,
    input  logic             id_wr_en,
    input  logic             id_wr2_en,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rd2,
    input  logic             id_is_load,
    input  logic             ex_flush,
    input  logic             mem_stall,
    output logic             id_stall,
    output logic [1:0]       alu_input1_sel,
    output logic [1:0]       alu_input2_sel,
    output logic [1:0]       store_val_sel,
    output logic [2:0]       alu_input1_sel_C,
    output logic [2:0]       alu_input2_sel_C,
    output logic [2:0]       alu_input3_sel_C,
    output logic [2:0]       alu_input4_sel_C,
    output logic [2:0]       store_val_sel_C,
    output logic [2:0]       store_val2_sel,
    output logic             ex_complex
);

    stage_tag_t       ex_tag_q;
    stage_tag_t       mem_tag_q;
    stage_tag_t       wb_tag_q;
    stage_tag_t       id_tag_c;
    logic [REG_W-1:0] src_c      [NUM_SRC];
    sel3_t            sel_c      [NUM_SRC];
    logic [NUM_SRC-1:0] load_hit_c;
    logic             issue_c;
    logic             complex_c;
    logic             unused_wb_tag;

    assign src_c[0] = id_rs;
    assign src_c[1] = id_rt;
    assign src_c[2] = id_rs3;
    assign src_c[3] = id_rs4;
    assign src_c[4] = id_st_rs;
    assign src_c[5] = id_st2_rs;

    // One matcher per operand source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        exe_fwd_match u_match (
            .src      (src_c[i]),
            .ex_tag   (ex_tag_q),
            .mem_tag  (mem_tag_q),
            .sel      (sel_c[i]),
            .load_hit (load_hit_c[i])
        );
    end

    // Load-use stall; flush, memory stall and reset all suppress it.
    assign id_stall = !rst && !mem_stall && !ex_flush && id_valid && (|load_hit_c);

    assign issue_c = id_valid && !id_stall && !ex_flush;

    // Second-result forwarding on any simple-datapath operand needs the complex path.
    assign complex_c = id_complex
                     || is_second_result(sel_c[0])
                     || is_second_result(sel_c[1])
                     || is_second_result(sel_c[4]);

    // Destination tag of the instruction currently in ID.
    always_comb begin
        id_tag_c         = '0;
        id_tag_c.valid   = 1'b1;
        id_tag_c.wr_en   = id_wr_en;
        id_tag_c.rd      = id_rd;
        id_tag_c.wr2_en  = id_wr2_en;
        id_tag_c.rd2     = id_rd2;
        id_tag_c.is_load = id_is_load;
    end

    // The WB distance is covered by register-file write-through.
    assign unused_wb_tag = ^wb_tag_q;

    // Advance tags and register selects; bubbles carry all-zero selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag_q         <= '0;
            mem_tag_q        <= '0;
            wb_tag_q         <= '0;
            alu_input1_sel   <= SEL2_STAGE;
            alu_input2_sel   <= SEL2_STAGE;
            store_val_sel    <= SEL2_STAGE;
            alu_input1_sel_C <= SEL3_STAGE;
            alu_input2_sel_C <= SEL3_STAGE;
            alu_input3_sel_C <= SEL3_STAGE;
            alu_input4_sel_C <= SEL3_STAGE;
            store_val_sel_C  <= SEL3_STAGE;
            store_val2_sel   <= SEL3_STAGE;
            ex_complex       <= 1'b0;
        end else if (!mem_stall) begin
            ex_tag_q         <= issue_c ? id_tag_c : '0;
            mem_tag_q        <= ex_tag_q;
            wb_tag_q         <= mem_tag_q;
            alu_input1_sel   <= issue_c ? to_sel2(sel_c[0]) : SEL2_STAGE;
            alu_input2_sel   <= issue_c ? to_sel2(sel_c[1]) : SEL2_STAGE;
            store_val_sel    <= issue_c ? to_sel2(sel_c[4]) : SEL2_STAGE;
            alu_input1_sel_C <= issue_c ? sel_c[0] : SEL3_STAGE;
            alu_input2_sel_C <= issue_c ? sel_c[1] : SEL3_STAGE;
            alu_input3_sel_C <= issue_c ? sel_c[2] : SEL3_STAGE;
            alu_input4_sel_C <= issue_c ? sel_c[3] : SEL3_STAGE;
            store_val_sel_C  <= issue_c ? sel_c[4] : SEL3_STAGE;
            store_val2_sel   <= issue_c ? sel_c[5] : SEL3_STAGE;
            ex_complex       <= issue_c && complex_c;
        end
    end

endmodule

// File: tb/tb_exe_fwd_ctrl.sv
// Directed bench for exe_fwd_ctrl with hand-computed expected selects.
module tb_exe_fwd_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_complex;
    logic [4:0] id_rs, id_rt, id_rs3, id_rs4, id_st_rs, id_st2_rs;
    logic       id_wr_en, id_wr2_en;
    logic [4:0] id_rd, id_rd2;
    logic       id_is_load;
    logic       ex_flush;
    logic       mem_stall;
    logic       id_stall;
    logic [1:0] alu_input1_sel, alu_input2_sel, store_val_sel;
    logic [2:0] alu_input1_sel_C, alu_input2_sel_C, alu_input3_sel_C;
    logic [2:0] alu_input4_sel_C, store_val_sel_C, store_val2_sel;
    logic       ex_complex;

    int n_checks;
    int n_errors;

    exe_fwd_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_complex       (id_complex),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rs3           (id_rs3),
        .id_rs4           (id_rs4),
        .id_st_rs         (id_st_rs),
        .id_st2_rs        (id_st2_rs),
        .id_wr_en         (id_wr_en),
        .id_wr2_en        (id_wr2_en),
        .id_rd            (id_rd),
        .id_rd2           (id_rd2),
        .id_is_load       (id_is_load),
        .ex_flush         (ex_flush),
        .mem_stall        (mem_stall),
        .id_stall         (id_stall),
        .alu_input1_sel   (alu_input1_sel),
        .alu_input2_sel   (alu_input2_sel),
        .store_val_sel    (store_val_sel),
        .alu_input1_sel_C (alu_input1_sel_C),
        .alu_input2_sel_C (alu_input2_sel_C),
        .alu_input3_sel_C (alu_input3_sel_C),
        .alu_input4_sel_C (alu_input4_sel_C),
        .store_val_sel_C  (store_val_sel_C),
        .store_val2_sel   (store_val2_sel),
        .ex_complex       (ex_complex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        id_valid   = 1'b0;
        id_complex = 1'b0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_rs3     = 5'd0;
        id_rs4     = 5'd0;
        id_st_rs   = 5'd0;
        id_st2_rs  = 5'd0;
        id_wr_en   = 1'b0;
        id_wr2_en  = 1'b0;
        id_rd      = 5'd0;
        id_rd2     = 5'd0;
        id_is_load = 1'b0;
    endtask

    task automatic idle(input int n);
        clr_id();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sel1"},   32'(alu_input1_sel),   32'd0);
        check({tag, ".sel2"},   32'(alu_input2_sel),   32'd0);
        check({tag, ".stsel"},  32'(store_val_sel),    32'd0);
        check({tag, ".sel1C"},  32'(alu_input1_sel_C), 32'd0);
        check({tag, ".sel2C"},  32'(alu_input2_sel_C), 32'd0);
        check({tag, ".sel3C"},  32'(alu_input3_sel_C), 32'd0);
        check({tag, ".sel4C"},  32'(alu_input4_sel_C), 32'd0);
        check({tag, ".stselC"}, 32'(store_val_sel_C),  32'd0);
        check({tag, ".st2sel"}, 32'(store_val2_sel),   32'd0);
        check({tag, ".cplx"},   32'(ex_complex),       32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        ex_flush  = 1'b0;
        mem_stall = 1'b0;
        clr_id();

        // Reset state; stall held low while in reset even with a request.
        tick();
        tick();
        id_valid = 1'b1;
        id_rs    = 5'd3;
        #1;
        check("rst_stall", 32'(id_stall), 32'd0);
        check_zero("rst");
        rst = 1'b0;
        clr_id();

        // ADD r3 then SUB using r3; first instruction after reset sees nothing.
        id_valid = 1'b1; id_rs = 5'd3; id_wr_en = 1'b1; id_rd = 5'd3;
        #1;
        check("add_stall", 32'(id_stall), 32'd0);
        tick();
        check("first_sel1C", 32'(alu_input1_sel_C), 32'd0);
        clr_id();
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_wr_en = 1'b1; id_rd = 5'd4;
        #1;
        check("sub_stall", 32'(id_stall), 32'd0);
        tick();
        check("sub_sel1",  32'(alu_input1_sel),   32'h1);
        check("sub_sel1C", 32'(alu_input1_sel_C), 32'h1);
        check("sub_sel2",  32'(alu_input2_sel),   32'h0);
        check("sub_cplx",  32'(ex_complex),       32'h0);
        idle(3);
        check_zero("drain1");

        // Complex writes r5/r6, one unrelated op, then rs3=6 and rs=5 from MEM.
        id_valid = 1'b1; id_complex = 1'b1; id_wr_en = 1'b1; id_rd = 5'd5;
        id_wr2_en = 1'b1; id_rd2 = 5'd6;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs = 5'd11; id_wr_en = 1'b1; id_rd = 5'd10;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs3 = 5'd6; id_rs = 5'd5;
        tick();
        check("wb2_sel3C", 32'(alu_input3_sel_C), 32'h4);
        check("wb1_sel1C", 32'(alu_input1_sel_C), 32'h2);
        check("wb1_sel1",  32'(alu_input1_sel),   32'h2);
        check("wb2_cplx",  32'(ex_complex),       32'h0);
        idle(3);

        // LW r7 then ADD using r7 as rt: one stall cycle, bubble, then WB forward.
        id_valid = 1'b1; id_is_load = 1'b1; id_wr_en = 1'b1; id_rd = 5'd7;
        #1;
        check("lw_stall", 32'(id_stall), 32'd0);
        tick();
        clr_id();
        id_valid = 1'b1; id_rt = 5'd7; id_wr_en = 1'b1; id_rd = 5'd8;
        #1;
        check("lu_stall1", 32'(id_stall), 32'd1);
        tick();
        check_zero("lu_bubble");
        check("lu_stall2", 32'(id_stall), 32'd0);
        tick();
        check("lu_sel2",  32'(alu_input2_sel),   32'h2);
        check("lu_sel2C", 32'(alu_input2_sel_C), 32'h2);
        idle(3);

        // Same load-use with a flush in the stall cycle.
        id_valid = 1'b1; id_is_load = 1'b1; id_wr_en = 1'b1; id_rd = 5'd12;
        tick();
        clr_id();
        id_valid = 1'b1; id_rt = 5'd12; id_wr_en = 1'b1; id_rd = 5'd14;
        ex_flush = 1'b1;
        #1;
        check("fl_stall", 32'(id_stall), 32'd0);
        tick();
        ex_flush = 1'b0;
        check_zero("fl_bubble");
        clr_id();
        id_valid = 1'b1; id_rs = 5'd14;
        tick();
        check("fl_nofwd", 32'(alu_input1_sel_C), 32'h0);
        idle(3);

        // rd2 producer forwarded to a simple op forces the complex path.
        id_valid = 1'b1; id_complex = 1'b1; id_wr_en = 1'b1; id_rd = 5'd15;
        id_wr2_en = 1'b1; id_rd2 = 5'd9;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs = 5'd9; id_rt = 5'd15;
        tick();
        check("r2_sel1C", 32'(alu_input1_sel_C), 32'h3);
        check("r2_sel1",  32'(alu_input1_sel),   32'h0);
        check("r2_cplx",  32'(ex_complex),       32'h1);
        check("r2_sel2C", 32'(alu_input2_sel_C), 32'h1);
        check("r2_sel2",  32'(alu_input2_sel),   32'h1);
        idle(3);

        // EX beats MEM; store_val2 second-result alone does not set ex_complex.
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = 5'd17;
        tick();
        clr_id();
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = 5'd17; id_wr2_en = 1'b1; id_rd2 = 5'd22;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs = 5'd17; id_st_rs = 5'd17; id_st2_rs = 5'd22;
        tick();
        check("pri_sel1C",  32'(alu_input1_sel_C), 32'h1);
        check("pri_stselC", 32'(store_val_sel_C),  32'h1);
        check("pri_stsel",  32'(store_val_sel),    32'h1);
        check("pri_st2sel", 32'(store_val2_sel),   32'h3);
        check("pri_cplx",   32'(ex_complex),       32'h0);
        idle(3);

        // Same register on rd and rd2: rd2 wins.
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = 5'd23; id_wr2_en = 1'b1; id_rd2 = 5'd23;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs4 = 5'd23;
        tick();
        check("rd2pri_sel4C", 32'(alu_input4_sel_C), 32'h3);
        idle(3);

        // r0 never forwards; rd without wr_en never matches.
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = 5'd0; id_wr2_en = 1'b0; id_rd2 = 5'd24;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs = 5'd0; id_rt = 5'd24;
        tick();
        check("r0_sel1C",  32'(alu_input1_sel_C), 32'h0);
        check("nowe_sel2C", 32'(alu_input2_sel_C), 32'h0);
        idle(3);

        // mem_stall for 3 cycles holds outputs and tags, and masks the stall.
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = 5'd18;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs = 5'd18; id_is_load = 1'b1; id_wr_en = 1'b1; id_rd = 5'd19;
        tick();
        check("ms_pre_sel1", 32'(alu_input1_sel), 32'h1);
        clr_id();
        id_valid = 1'b1; id_rs = 5'd19;
        mem_stall = 1'b1;
        #1;
        check("ms_stall", 32'(id_stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ms_hold_sel1_%0d", i),  32'(alu_input1_sel),   32'h1);
            check($sformatf("ms_hold_sel1C_%0d", i), 32'(alu_input1_sel_C), 32'h1);
        end
        mem_stall = 1'b0;
        #1;
        check("ms_rel_stall", 32'(id_stall), 32'd1);
        tick();
        check("ms_bubble_sel1", 32'(alu_input1_sel), 32'h0);
        tick();
        check("ms_post_sel1", 32'(alu_input1_sel), 32'h2);

        // Reset mid-stream overrides mem_stall; next instruction sees no forwarding.
        clr_id();
        id_valid = 1'b1; id_wr_en = 1'b1; id_rd = 5'd21; id_complex = 1'b1;
        tick();
        clr_id();
        id_valid = 1'b1; id_rs = 5'd21; id_rt = 5'd21;
        rst = 1'b1;
        mem_stall = 1'b1;
        #1;
        check("mr_stall", 32'(id_stall), 32'd0);
        tick();
        check_zero("mr");
        rst = 1'b0;
        mem_stall = 1'b0;
        tick();
        check("mr_first_sel1C", 32'(alu_input1_sel_C), 32'h0);
        check("mr_first_sel2C", 32'(alu_input2_sel_C), 32'h0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
